// File: rtl/vga_pixel_fifo.sv
// Elastic 12-bit pixel buffer between the pixel source and VGA scanout, vga_clk domain.
// Registered colour outputs, black during blanking, sticky underflow, frame-start flush.
module vga_pixel_fifo #(
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [11:0]      wr_data,
  input  logic             rd_en,
  output logic [3:0]       redvga,
  output logic [3:0]       grnvga,
  output logic [3:0]       bluvga,
  output logic [LVL_W-1:0] level,
  output logic             underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);

  logic [11:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             empty;
  logic             do_wr;
  logic             do_rd;

  // Full/empty come from the occupancy counter so pointer equality is never ambiguous.
  assign empty    = (level == '0);
  assign wr_ready = (level != LVL_FULL);
  assign do_wr    = wr_valid && wr_ready && !flush;
  assign do_rd    = rd_en && !empty && !flush;

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  // No write-to-read bypass: an empty pop outputs black even if a write lands on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {redvga, grnvga, bluvga} <= 12'h000;
      underflow                <= 1'b0;
    end else if (flush) begin
      {redvga, grnvga, bluvga} <= 12'h000;
      underflow                <= 1'b0;
    end else begin
      if (do_rd) begin
        {redvga, grnvga, bluvga} <= mem[rd_ptr];
      end else begin
        {redvga, grnvga, bluvga} <= 12'h000;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_pixel_fifo.sv
// Self-checking bench for vga_pixel_fifo: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, line-rate streaming and random traffic.
module tb_vga_pixel_fifo;
  localparam int DEPTH = 16;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             flush = 1'b0;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [11:0]      wr_data = 12'h000;
  logic             rd_en = 1'b0;
  logic [3:0]       redvga, grnvga, bluvga;
  logic [LVL_W-1:0] level;
  logic             underflow;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  vga_pixel_fifo #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_en(rd_en), .redvga(redvga), .grnvga(grnvga), .bluvga(bluvga),
    .level(level), .underflow(underflow)
  );

  always #5 clk = ~clk;

  wire [11:0] colour = {redvga, grnvga, bluvga};

  // Reference model: a queue holding the buffered words in arrival order.
  logic [11:0] mq[$];
  logic [11:0] m_col = 12'h000;
  logic        m_uf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_col = 12'h000;
      m_uf  = 1'b0;
    end else if (flush) begin
      mq.delete();
      m_col = 12'h000;
      m_uf  = 1'b0;
    end else begin
      automatic bit accept = wr_valid && (mq.size() < DEPTH);
      if (rd_en) begin
        if (mq.size() > 0) m_col = mq.pop_front();
        else begin
          m_col = 12'h000;
          m_uf  = 1'b1;
        end
      end else begin
        m_col = 12'h000;
      end
      if (accept) mq.push_back(wr_data);
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_level", 32'(level), 32'(mq.size()));
      check("model_wr_ready", 32'(wr_ready), 32'(mq.size() < DEPTH));
      check("model_colour", 32'(colour), 32'(m_col));
      check("model_underflow", 32'(underflow), 32'(m_uf));
      check("level_bound", 32'(level <= LVL_W'(DEPTH)), 32'd1);
    end
  end

  // Apply inputs for one cycle; returns #1 after the rising edge.
  task automatic cyc(input logic f, input logic wv, input logic [11:0] wd, input logic re);
    flush = f; wr_valid = wv; wr_data = wd; rd_en = re;
    @(posedge clk);
    #1;
  endtask

  initial begin
    automatic logic [11:0] grad = 12'h000;
    #1 rst_n = 1'b0;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;

    // Some traffic, then an asynchronous reset mid-stream.
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 12'(i + 12'h100), i[0]);
    cyc(1'b0, 1'b1, 12'h3C3, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_colour", 32'(colour), 32'h0);
    check("rst_level", 32'(level), 32'h0);
    check("rst_wr_ready", 32'(wr_ready), 32'h1);
    check("rst_underflow", 32'(underflow), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Fill with 0x001..0x010, then a refused 17th write.
    for (int i = 1; i <= DEPTH; i++) cyc(1'b0, 1'b1, 12'(i), 1'b0);
    check("fill_level", 32'(level), 32'd16);
    check("fill_wr_ready", 32'(wr_ready), 32'h0);
    cyc(1'b0, 1'b1, 12'h0FF, 1'b0);
    check("fill_17th_level", 32'(level), 32'd16);

    // Drain in order, one clock after each rd_en.
    for (int i = 1; i <= DEPTH; i++) begin
      cyc(1'b0, 1'b0, 12'h000, 1'b1);
      check("drain_colour", 32'(colour), 32'(i));
      check("drain_level", 32'(level), 32'(DEPTH - i));
    end
    check("drain_underflow", 32'(underflow), 32'h0);
    cyc(1'b0, 1'b0, 12'h000, 1'b0);
    check("blank_colour", 32'(colour), 32'h0);

    // Underflow is sticky through later writes until flush.
    cyc(1'b0, 1'b0, 12'h000, 1'b1);
    check("uf_colour", 32'(colour), 32'h0);
    check("uf_flag", 32'(underflow), 32'h1);
    cyc(1'b0, 1'b1, 12'hABC, 1'b0);
    check("uf_sticky", 32'(underflow), 32'h1);
    check("uf_write_level", 32'(level), 32'd1);
    cyc(1'b1, 1'b0, 12'h000, 1'b0);
    check("flush_uf", 32'(underflow), 32'h0);
    check("flush_level", 32'(level), 32'h0);

    // Full with write+read: write refused, pop proceeds.
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b1, 12'(12'h200 + i), 1'b0);
    cyc(1'b0, 1'b1, 12'h777, 1'b1);
    check("full_both_level", 32'(level), 32'd15);
    check("full_both_colour", 32'(colour), 32'h200);
    check("full_pop_wr_ready", 32'(wr_ready), 32'h1);
    for (int i = 1; i < DEPTH; i++) cyc(1'b0, 1'b0, 12'h000, 1'b1);
    check("full_last_colour", 32'(colour), 32'h20F);

    // Empty with write+read: no bypass.
    check("empty_pre_level", 32'(level), 32'h0);
    cyc(1'b0, 1'b1, 12'h123, 1'b1);
    check("empty_both_level", 32'(level), 32'd1);
    check("empty_both_colour", 32'(colour), 32'h0);
    check("empty_both_uf", 32'(underflow), 32'h1);
    cyc(1'b0, 1'b0, 12'h000, 1'b1);
    check("empty_then_pop", 32'(colour), 32'h123);

    // Flush with concurrent write and read at level 5.
    cyc(1'b1, 1'b0, 12'h000, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 12'(12'h050 + i), 1'b0);
    check("pre_flush_level", 32'(level), 32'd5);
    cyc(1'b1, 1'b1, 12'h5A5, 1'b1);
    check("flush3_level", 32'(level), 32'h0);
    check("flush3_uf", 32'(underflow), 32'h0);
    check("flush3_colour", 32'(colour), 32'h0);
    cyc(1'b0, 1'b0, 12'h000, 1'b1);
    check("flush3_discard", 32'(colour), 32'h0);

    // Streaming at 800-clock lines with a gradient source.
    cyc(1'b1, 1'b0, 12'h000, 1'b0);
    for (int c = 0; c < 8; c++) begin
      automatic bit acc = wr_ready;
      cyc(1'b0, 1'b1, grad, 1'b0);
      if (acc) grad++;
    end
    for (int ln = 0; ln < 3; ln++) begin
      for (int c = 0; c < 800; c++) begin
        automatic bit acc = wr_ready;
        cyc(1'b0, 1'b1, grad, c < 640);
        if (acc) grad++;
      end
    end
    check("stream_underflow", 32'(underflow), 32'h0);

    // Random traffic, occasional flush.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(63) == 0), 1'($urandom), 12'($urandom), 1'($urandom));
    end
    cyc(1'b0, 1'b0, 12'h000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vga_pixel_fifo.md
# vga_pixel_fifo

Elastic pixel buffer between the pixel source (pattern/framebuffer logic) and the VGA scanout/timing stage, all in the `vga_clk` domain. The producer pushes 12-bit RGB words with a valid/ready handshake. The scanout stage pops one word per active-video clock and receives registered 4-bit red/green/blue outputs. Blanking is forced to black, an empty-FIFO pop is flagged as underflow, and a frame-start flush realigns the buffer every frame.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; must be a power of two, at least 4.
- `LVL_W`, clog2(DEPTH)+1: width of `level`.

Ports:
- `clk` in 1: pixel clock (`vga_clk`). One clock; every flop sits on its rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `flush` in 1: synchronous frame-start clear, pulsed by the timing stage at line 0, column 0.
- `wr_valid` in 1: the producer has a word on `wr_data`.
- `wr_ready` out 1: the FIFO can accept a word this cycle.
- `wr_data` in 12: pixel word, {red[3:0], grn[3:0], blu[3:0]}.
- `rd_en` in 1: scanout is in active video and consumes one pixel this cycle.
- `redvga`, `grnvga`, `bluvga` out 4 each: registered pixel colour.
- `level` out LVL_W: current occupancy, 0..DEPTH.
- `underflow` out 1: sticky flag, set by any pop on an empty FIFO.

## Operation
- Storage: `DEPTH` x 12 register array.
- Pointers: write and read pointers, each clog2(DEPTH) bits, wrapping modulo DEPTH.
- Occupancy: `level` is a registered counter.
- Full and empty are decoded from `level` only (`level`==DEPTH, `level`==0), never from pointer comparison.
- `wr_ready` = (`level` != DEPTH), combinational from the registered `level`.
- Write: accepted when `wr_valid` && `wr_ready`. `wr_data` is stored at the write pointer, which then increments.
- Read with `rd_en`=1 and `level`>0:
  - the word at the read pointer is loaded into `redvga`/`grnvga`/`bluvga` on the same edge;
  - the read pointer increments.
- Read with `rd_en`=1 and `level`==0:
  - colour outputs load 0;
  - `underflow` is set;
  - pointers and `level` are unchanged.
- `rd_en`=0: colour outputs load 0 (blanking is black). Pointers are unchanged.
- `level` update each cycle:
  - +1 on a write with no pop;
  - -1 on a pop with no write;
  - unchanged when both or neither occur.
- A write and a pop in the same cycle are both legal whenever `level` is between 1 and DEPTH-1.
- Empty plus simultaneous write and `rd_en`: there is no bypass. The write is stored, the read underflows and outputs 0, and `level` goes 0→1.
- Full plus simultaneous `wr_valid` and `rd_en`: `wr_ready` is 0, so the write is refused. The pop proceeds and `level` goes DEPTH→DEPTH-1.
- `flush`=1 has priority over any write or read in the same cycle. On that edge:
  - both pointers go to 0;
  - `level` goes to 0;
  - `underflow` goes to 0;
  - colour outputs go to 0;
  - any concurrent write is discarded.
- `underflow` clears only on `flush` or reset.
- `level` arithmetic: unsigned. Overflow and underflow of the counter are impossible by construction; the bench asserts this.

## Timing
- Reset (`rst_n`=0, asynchronous): `redvga`=`grnvga`=`bluvga`=0, `level`=0, `underflow`=0, both pointers 0. `wr_ready` therefore reads 1.
- Reset release takes effect on the first rising edge after `rst_n` rises.
- Asserting reset mid-operation discards all contents immediately, without waiting for a clock edge.
- Read latency is 1 clock: the colour for the `rd_en` in cycle N appears after edge N and is valid during cycle N+1. The timing stage delays hsync/vsync by one clock to match.
- Write-to-readable latency is 1 clock: a word written at edge N can be popped in cycle N+1.
- `wr_ready` responds to a pop within the same cycle's registered `level`. A full FIFO that pops at edge N shows `wr_ready`=1 in cycle N+1.
- Throughput: one write and one read per clock, sustained.

## Test plan
- Reset and fill: assert `rst_n`=0 mid-stream, then release. Check all outputs are 0 and `wr_ready`=1. Write 0x001, 0x002, … 0x010 with `rd_en`=0. Expect `level`=16, `wr_ready`=0, and the 17th `wr_valid` ignored.
- Drain order: from a full FIFO, hold `rd_en`=1 for 16 cycles. Expect colours 0x001..0x010 in order, one clock after each `rd_en`, `level` counting 16→0, `underflow`=0.
- Underflow: with `level`=0, pulse `rd_en` once. Expect colour 0x000 and `underflow`=1 on the next cycle. `underflow` stays 1 through later writes until `flush`.
- Simultaneous flush, write and read: `level`=5, then `flush`=`wr_valid`=`rd_en`=1 in one cycle. Expect `level`=0, `underflow`=0, colour 0, and that the written word is never read.
- Streaming at 800-clock lines: pixel source writes a gradient 0x000..0xFFF while `rd_en` follows 640 active and 160 blank clocks. Expect no underflow, output equal to the input sequence delayed, black during blanking, and `level` never above DEPTH.
- Edge cases: full with `wr_valid`+`rd_en` gives `level` 16→15 and the write refused. Empty with `wr_valid`+`rd_en` gives `level` 0→1, output 0 and `underflow`=1.
